// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with flush, thresholds and optional FWFT read
// Level flags decode count combinationally; handshake/error flags are registered one-cycle pulses.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL));
  assign almostempty = (count_q <= CW'(AE_LEVEL));
  assign count       = count_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // Acceptance is judged on pre-edge occupancy; flush suppresses both ports.
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wr_ack_d    = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
// Three instances: default depth 8, depth 5 for wrap, depth 4 in FWFT mode.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_flush, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  logic        b_rst, b_flush, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;

  logic        c_rst, c_flush, c_wr, c_rd;
  logic [15:0] c_din, c_dout;
  logic        c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [2:0]  c_cnt;

  sync_fifo_param u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
    .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf), .full(a_full),
    .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_cnt)
  );

  sync_fifo_param #(.FIFO_DEPTH(5)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
    .data_out(b_dout), .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf), .full(b_full),
    .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_cnt)
  );

  sync_fifo_param #(.FIFO_DEPTH(4), .FWFT(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .flush(c_flush), .wr_en(c_wr), .data_in(c_din), .rd_en(c_rd),
    .data_out(c_dout), .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf), .full(c_full),
    .empty(c_empty), .almostfull(c_af), .almostempty(c_ae), .count(c_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1; b_rst = 1; c_rst = 1;
    tick();
    a_rst = 0; b_rst = 0; c_rst = 0;
    checks++; if (a_cnt !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", a_empty); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", a_full); end
    checks++; if (a_af !== 1'b0) begin errors++; $display("FAIL reset_almostfull got %b exp 0", a_af); end
    checks++; if (a_ae !== 1'b1) begin errors++; $display("FAIL reset_almostempty got %b exp 1", a_ae); end
    checks++; if ({a_ack, a_ovf, a_udf} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {a_ack, a_ovf, a_udf}); end
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h exp 0000", a_dout); end
    checks++; if (b_cnt !== 3'd0 || c_empty !== 1'b1) begin errors++; $display("FAIL reset_other got b_cnt %0d c_empty %b exp 0 1", b_cnt, c_empty); end
  endtask

  task automatic test_fill();
    a_wr = 1;
    for (int i = 1; i <= 8; i++) begin
      a_din = 16'(i);
      tick();
      checks++; if (a_ack !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d] got %b exp 1", i, a_ack); end
      checks++; if (a_cnt !== 4'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_cnt, i); end
      checks++; if (a_full !== (i == 8)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, a_full, i == 8); end
      checks++; if (a_af !== (i >= 7)) begin errors++; $display("FAIL fill_almostfull[%0d] got %b exp %b", i, a_af, i >= 7); end
      checks++; if (a_ae !== (i <= 1)) begin errors++; $display("FAIL fill_almostempty[%0d] got %b exp %b", i, a_ae, i <= 1); end
    end
    a_din = 16'h0009;
    tick();
    a_wr = 0;
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", a_ovf); end
    checks++; if (a_ack !== 1'b0) begin errors++; $display("FAIL fill_ack_on_full got %b exp 0", a_ack); end
    checks++; if (a_cnt !== 4'd8) begin errors++; $display("FAIL fill_count_on_full got %0d exp 8", a_cnt); end
  endtask

  task automatic test_drain();
    a_rd = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (a_dout !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, a_dout, 16'(i)); end
      checks++; if (a_cnt !== 4'(8 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, a_cnt, 8 - i); end
      checks++; if (a_empty !== (i == 8)) begin errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, a_empty, i == 8); end
    end
    tick();
    a_rd = 0;
    checks++; if (a_udf !== 1'b1) begin errors++; $display("FAIL drain_underflow got %b exp 1", a_udf); end
    checks++; if (a_dout !== 16'h0008) begin errors++; $display("FAIL drain_hold got %h exp 0008", a_dout); end
    tick();
    checks++; if (a_udf !== 1'b0) begin errors++; $display("FAIL drain_underflow_clear got %b exp 0", a_udf); end
  endtask

  task automatic test_simultaneous();
    a_wr = 1; a_rd = 1; a_din = 16'h0055;
    tick();
    checks++; if (a_cnt !== 4'd1) begin errors++; $display("FAIL sim_empty_count got %0d exp 1", a_cnt); end
    checks++; if ({a_ack, a_udf, a_ovf} !== 3'b110) begin errors++; $display("FAIL sim_empty_flags got %b exp 110", {a_ack, a_udf, a_ovf}); end
    checks++; if (a_dout !== 16'h0008) begin errors++; $display("FAIL sim_empty_hold got %h exp 0008", a_dout); end
    a_rd = 0;
    for (int k = 1; k <= 7; k++) begin
      a_din = 16'h0100 + 16'(k);
      tick();
    end
    checks++; if (a_cnt !== 4'd8) begin errors++; $display("FAIL sim_refill_count got %0d exp 8", a_cnt); end
    a_rd = 1; a_din = 16'hDEAD;
    tick();
    checks++; if (a_cnt !== 4'd7) begin errors++; $display("FAIL sim_full_count got %0d exp 7", a_cnt); end
    checks++; if ({a_ack, a_ovf, a_udf} !== 3'b010) begin errors++; $display("FAIL sim_full_flags got %b exp 010", {a_ack, a_ovf, a_udf}); end
    checks++; if (a_dout !== 16'h0055) begin errors++; $display("FAIL sim_full_data got %h exp 0055", a_dout); end
    a_wr = 0;
    for (int k = 1; k <= 4; k++) tick();
    checks++; if (a_cnt !== 4'd3 || a_dout !== 16'h0104) begin errors++; $display("FAIL sim_drain4 got cnt %0d data %h exp 3 0104", a_cnt, a_dout); end
    a_wr = 1; a_din = 16'h0200;
    tick();
    a_wr = 0; a_rd = 0;
    checks++; if (a_cnt !== 4'd3) begin errors++; $display("FAIL sim_mid_count got %0d exp 3", a_cnt); end
    checks++; if ({a_ack, a_ovf, a_udf} !== 3'b100) begin errors++; $display("FAIL sim_mid_flags got %b exp 100", {a_ack, a_ovf, a_udf}); end
    checks++; if (a_dout !== 16'h0105) begin errors++; $display("FAIL sim_mid_data got %h exp 0105", a_dout); end
  endtask

  task automatic test_flush();
    a_wr = 1; a_din = 16'h0201; tick();
    a_din = 16'h0202; tick();
    checks++; if (a_cnt !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", a_cnt); end
    a_flush = 1; a_rd = 1; a_din = 16'h0BAD;
    tick();
    a_flush = 0; a_rd = 0;
    checks++; if (a_cnt !== 4'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL flush_count got cnt %0d empty %b exp 0 1", a_cnt, a_empty); end
    checks++; if ({a_ack, a_ovf, a_udf} !== 3'b000) begin errors++; $display("FAIL flush_flags got %b exp 000", {a_ack, a_ovf, a_udf}); end
    checks++; if (a_dout !== 16'h0105) begin errors++; $display("FAIL flush_data_hold got %h exp 0105", a_dout); end
    a_din = 16'h0300; tick();
    a_wr = 0; a_rd = 1; tick();
    a_rd = 0;
    checks++; if (a_dout !== 16'h0300 || a_cnt !== 4'd0) begin errors++; $display("FAIL flush_resume got data %h cnt %0d exp 0300 0", a_dout, a_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    a_wr = 1;
    a_din = 16'h0401; tick();
    a_din = 16'h0402; tick();
    a_rd = 1; a_rst = 1; a_din = 16'h0403;
    tick();
    a_rst = 0; a_rd = 0;
    checks++; if (a_cnt !== 4'd0 || a_empty !== 1'b1 || a_ae !== 1'b1) begin errors++; $display("FAIL rstmid_level got cnt %0d empty %b ae %b exp 0 1 1", a_cnt, a_empty, a_ae); end
    checks++; if ({a_ack, a_ovf, a_udf} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", {a_ack, a_ovf, a_udf}); end
    checks++; if (a_dout !== 16'h0000) begin errors++; $display("FAIL rstmid_data got %h exp 0000", a_dout); end
    a_din = 16'h0404; tick();
    a_wr = 0;
    checks++; if (a_ack !== 1'b1 || a_cnt !== 4'd1) begin errors++; $display("FAIL rstmid_resume got ack %b cnt %0d exp 1 1", a_ack, a_cnt); end
  endtask

  task automatic test_wrap();
    b_wr = 1;
    for (int k = 0; k < 5; k++) begin
      b_din = 16'h00A0 + 16'(k);
      tick();
    end
    checks++; if (b_full !== 1'b1 || b_cnt !== 3'd5) begin errors++; $display("FAIL wrap_full got full %b cnt %0d exp 1 5", b_full, b_cnt); end
    b_wr = 0; b_rd = 1; tick();
    checks++; if (b_dout !== 16'h00A0 || b_cnt !== 3'd4) begin errors++; $display("FAIL wrap_first got %h cnt %0d exp 00a0 4", b_dout, b_cnt); end
    b_wr = 1;
    for (int k = 0; k < 7; k++) begin
      b_din = 16'h00A5 + 16'(k);
      tick();
      checks++; if (b_dout !== 16'h00A1 + 16'(k)) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", k, b_dout, 16'h00A1 + 16'(k)); end
      checks++; if (b_cnt !== 3'd4) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 4", k, b_cnt); end
    end
    b_wr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (b_dout !== 16'h00A8 + 16'(k)) begin errors++; $display("FAIL wrap_tail[%0d] got %h exp %h", k, b_dout, 16'h00A8 + 16'(k)); end
    end
    b_rd = 0;
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", b_empty); end
  endtask

  task automatic test_fwft();
    c_wr = 1; c_din = 16'hABCD; tick();
    c_wr = 0;
    checks++; if (c_dout !== 16'hABCD || c_empty !== 1'b0) begin errors++; $display("FAIL fwft_fall got %h empty %b exp abcd 0", c_dout, c_empty); end
    tick();
    checks++; if (c_dout !== 16'hABCD) begin errors++; $display("FAIL fwft_hold got %h exp abcd", c_dout); end
    c_wr = 1; c_din = 16'h1234; tick();
    c_wr = 0;
    checks++; if (c_dout !== 16'hABCD || c_cnt !== 3'd2) begin errors++; $display("FAIL fwft_head got %h cnt %0d exp abcd 2", c_dout, c_cnt); end
    c_rd = 1; tick();
    checks++; if (c_dout !== 16'h1234 || c_cnt !== 3'd1) begin errors++; $display("FAIL fwft_pop got %h cnt %0d exp 1234 1", c_dout, c_cnt); end
    tick();
    checks++; if (c_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty got %b exp 1", c_empty); end
    tick();
    c_rd = 0;
    checks++; if (c_udf !== 1'b1) begin errors++; $display("FAIL fwft_underflow got %b exp 1", c_udf); end
  endtask

  initial begin
    a_rst = 1; a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
    b_rst = 1; b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
    c_rst = 1; c_flush = 0; c_wr = 0; c_rd = 0; c_din = '0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_reset_mid_burst();
    test_wrap();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
